// File: rtl/shift_cmd_queue_pkg.sv
// Shared defaults and command record layout for the shift command queue.
package shift_cmd_queue_pkg;

   localparam int WIDTH_DEF  = 8;
   localparam int CTRL_W_DEF = 3;
   localparam int DEPTH_DEF  = 4;

   // A queued command is stored as {data, shamt}, data in the upper bits.
   typedef struct packed {
      logic [WIDTH_DEF-1:0]  data;
      logic [CTRL_W_DEF-1:0] shamt;
   } cmd_t;

   function automatic int cmd_width(input int width, input int ctrl_w);
      return width + ctrl_w;
   endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous FIFO for packed shift commands; push is ignored when full, pop when empty.
module shift_cmd_fifo
   import shift_cmd_queue_pkg::*;
#(
   parameter int W     = cmd_width(WIDTH_DEF, CTRL_W_DEF),
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign full   = (r_count == CNT_FULL);
   assign empty  = (r_count == {(AW+1){1'b0}});
   assign count  = r_count;
   assign rdata  = r_mem[r_rd_ptr];
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   // Storage array: written on accepted push, never reset (empty masks stale contents).
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   // Pointers wrap modulo DEPTH; count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/shift_cmd_queue.sv
// Command FIFO feeding an external barrel shifter, with a registered valid/ready result stage.
// Optional occupancy/accept statistics ports are enabled by defining SHIFT_Q_STATS_EN.
module shift_cmd_queue
   import shift_cmd_queue_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [WIDTH-1:0]      cmd_data,
   input  logic [CTRL_W-1:0]     cmd_shamt,
   output logic [WIDTH-1:0]      sh_in,
   output logic [CTRL_W-1:0]     sh_ctrl,
   input  logic [WIDTH-1:0]      sh_out,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WIDTH-1:0]      res_data,
   output logic [CTRL_W-1:0]     res_shamt
`ifdef SHIFT_Q_STATS_EN
   ,
   output logic [$clog2(DEPTH):0] q_count,
   output logic [15:0]            acc_cnt
`endif
);

   localparam int CMD_W = cmd_width(WIDTH, CTRL_W);

   logic [CMD_W-1:0]         w_rdata;
   logic                     w_full;
   logic                     w_empty;
   logic [$clog2(DEPTH):0]   w_count;
   logic                     w_push;
   logic                     w_load;
   logic                     r_res_valid;
   logic [WIDTH-1:0]         r_res_data;
   logic [CTRL_W-1:0]        r_res_shamt;

   // No bypass: a pop in the same cycle never reopens a full queue.
   assign cmd_ready = ~rst & ~w_full;
   assign w_push    = cmd_valid & cmd_ready;
   assign w_load    = ~w_empty & (~r_res_valid | res_ready);

   shift_cmd_fifo #(
      .W     (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_load),
      .wdata ({cmd_data, cmd_shamt}),
      .rdata (w_rdata),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // Present the queue head to the shifter; drive zeros when nothing is queued.
   always_comb begin
      sh_in   = {WIDTH{1'b0}};
      sh_ctrl = {CTRL_W{1'b0}};
      if (!w_empty) begin
         sh_in   = w_rdata[CMD_W-1:CTRL_W];
         sh_ctrl = w_rdata[CTRL_W-1:0];
      end else begin
         sh_in   = {WIDTH{1'b0}};
         sh_ctrl = {CTRL_W{1'b0}};
      end
   end

   // Result register: captures the shifter output on load, holds while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_res_valid <= 1'b0;
         r_res_data  <= {WIDTH{1'b0}};
         r_res_shamt <= {CTRL_W{1'b0}};
      end else if (w_load) begin
         r_res_valid <= 1'b1;
         r_res_data  <= sh_out;
         r_res_shamt <= w_rdata[CTRL_W-1:0];
      end else if (r_res_valid && res_ready) begin
         r_res_valid <= 1'b0;
      end else begin
         r_res_valid <= r_res_valid;
      end
   end

   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_shamt = r_res_shamt;

`ifdef SHIFT_Q_STATS_EN
   logic [15:0] r_acc_cnt;

   // Saturating count of accepted commands.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc_cnt <= 16'd0;
      end else if (w_push && (r_acc_cnt != 16'hFFFF)) begin
         r_acc_cnt <= r_acc_cnt + 16'd1;
      end else begin
         r_acc_cnt <= r_acc_cnt;
      end
   end

   assign q_count = w_count;
   assign acc_cnt = r_acc_cnt;
`endif

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Self-checking bench for shift_cmd_queue against a queue-based reference model.
module tb_shift_cmd_queue;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic [2:0] cmd_shamt;
   logic [7:0] sh_in;
   logic [2:0] sh_ctrl;
   logic [7:0] sh_out;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic [2:0] res_shamt;
`ifdef SHIFT_Q_STATS_EN
   logic [2:0]  q_count;
   logic [15:0] acc_cnt;
`endif

   always #5 clk = ~clk;

   // Stand-in for barrel_shifter_8bit: logical right shift.
   assign sh_out = sh_in >> sh_ctrl;

   shift_cmd_queue dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_shamt (cmd_shamt),
      .sh_in     (sh_in),
      .sh_ctrl   (sh_ctrl),
      .sh_out    (sh_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_shamt (res_shamt)
`ifdef SHIFT_Q_STATS_EN
      ,
      .q_count   (q_count),
      .acc_cnt   (acc_cnt)
`endif
   );

   typedef struct {
      logic [7:0] d;
      logic [2:0] s;
   } cmd_s;

   cmd_s       mq[$];
   bit         mv;
   logic [7:0] md;
   logic [2:0] ms;
   int         macc;
   int         n_checks = 0;
   int         n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // One clock: check outputs at negedge, advance the model at posedge, drive after #1.
   task automatic cycle();
      bit   do_push;
      bit   do_load;
      cmd_s c;
      @(negedge clk);
      check_val("cmd_ready", {31'd0, cmd_ready}, {31'd0, (!rst && mq.size() < DEPTH)});
      check_val("res_valid", {31'd0, res_valid}, {31'd0, mv});
      check_val("res_data", {24'd0, res_data}, {24'd0, md});
      check_val("res_shamt", {29'd0, res_shamt}, {29'd0, ms});
      check_val("sh_in", {24'd0, sh_in}, (mq.size() > 0) ? {24'd0, mq[0].d} : 32'd0);
      check_val("sh_ctrl", {29'd0, sh_ctrl}, (mq.size() > 0) ? {29'd0, mq[0].s} : 32'd0);
`ifdef SHIFT_Q_STATS_EN
      check_val("q_count", {29'd0, q_count}, mq.size());
      check_val("acc_cnt", {16'd0, acc_cnt}, macc);
`endif
      @(posedge clk);
      if (rst) begin
         mq.delete();
         mv = 1'b0; md = 8'd0; ms = 3'd0; macc = 0;
      end else begin
         do_push = cmd_valid && (mq.size() < DEPTH);
         do_load = (mq.size() > 0) && (!mv || res_ready);
         if (do_load) begin
            c  = mq.pop_front();
            md = c.d >> c.s;
            ms = c.s;
            mv = 1'b1;
         end else if (mv && res_ready) begin
            mv = 1'b0;
         end
         if (do_push) begin
            c.d = cmd_data;
            c.s = cmd_shamt;
            mq.push_back(c);
            if (macc < 65535) macc++;
         end
      end
      #1;
   endtask

   logic [7:0] t2_d [4] = '{8'd128, 8'd128, 8'd255, 8'd0};
   logic [2:0] t2_s [4] = '{3'd2, 3'd1, 3'd7, 3'd0};

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_data = 8'd0; cmd_shamt = 3'd0; res_ready = 1'b0;
      mv = 1'b0; md = 8'd0; ms = 3'd0; macc = 0;
      repeat (2) @(posedge clk);
      #1;
      cycle();
      rst = 1'b0;
      cycle();

      // Single command: result visible one cycle after accept.
      cmd_valid = 1'b1; cmd_data = 8'd128; cmd_shamt = 3'd4; res_ready = 1'b1;
      cycle();
      cmd_valid = 1'b0;
      cycle();
      check_val("t1_valid", {31'd0, res_valid}, 32'd1);
      check_val("t1_data", {24'd0, res_data}, 32'd8);
      check_val("t1_shamt", {29'd0, res_shamt}, 32'd4);
      repeat (2) cycle();

      // Back-to-back commands at full throughput.
      for (int i = 0; i < 4; i++) begin
         cmd_valid = 1'b1; cmd_data = t2_d[i]; cmd_shamt = t2_s[i];
         cycle();
      end
      cmd_valid = 1'b0;
      repeat (3) cycle();

      // Stalled consumer: fill to full, first result held.
      res_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cmd_valid = 1'b1; cmd_data = 8'(200 - i * 10); cmd_shamt = 3'(i + 1);
         cycle();
      end
      check_val("t3_full_ready", {31'd0, cmd_ready}, 32'd0);
      check_val("t3_hold_valid", {31'd0, res_valid}, 32'd1);
      check_val("t3_hold_data", {24'd0, res_data}, 32'd100);

      // Drain from full with push held.
      res_ready = 1'b1; cmd_valid = 1'b1; cmd_data = 8'hA5; cmd_shamt = 3'd3;
      repeat (3) cycle();
      cmd_valid = 1'b0;
      repeat (6) cycle();

      // Reset with queued commands and a held result.
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cmd_valid = 1'b1; cmd_data = 8'(17 * (i + 3)); cmd_shamt = 3'(i);
         cycle();
      end
      cmd_valid = 1'b0; rst = 1'b1;
      cycle();
      check_val("t5_rst_valid", {31'd0, res_valid}, 32'd0);
      rst = 1'b0;
      cmd_valid = 1'b1; cmd_data = 8'hF0; cmd_shamt = 3'd4; res_ready = 1'b1;
      cycle();
      cmd_valid = 1'b0;
      cycle();
      check_val("t5_after_data", {24'd0, res_data}, 32'h0F);
      repeat (2) cycle();

      // Randomized traffic with occasional reset.
      for (int n = 0; n < 800; n++) begin
         cmd_valid = ($urandom_range(0, 3) != 0);
         cmd_data  = 8'($urandom);
         cmd_shamt = 3'($urandom);
         res_ready = ($urandom_range(0, 2) != 0);
         rst       = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
      repeat (8) cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
